// File: rtl/cordic_phase_post_if.sv
// Handshake and data bundle between the phase post-processor and its neighbours.
// The input side carries CORDIC phase samples in; the output side carries block-average frequency results out.
interface cordic_phase_post_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] phase_in;
    logic [39:0] unwrap_out;
    logic [31:0] freq_out;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_valid, phase_in, out_ready,
        input  in_ready, unwrap_out, freq_out, out_valid
    );

    modport slave (
        input  in_valid, phase_in, out_ready,
        output in_ready, unwrap_out, freq_out, out_valid
    );
endinterface

// File: rtl/cordic_phase_post.sv
// Phase unwrapper and block-average frequency estimator behind a vectoring CORDIC.
// Phase is in degrees x 2^16; the frequency result is the mean wrapped phase step over 2^LOG2N steps.
module cordic_phase_post #(
    parameter int LOG2N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    cordic_phase_post_if.slave       bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic signed [32:0] HALF_TURN = 33'sd11796480;
    localparam logic signed [32:0] FULL_TURN = 33'sd23592960;

    logic [0:0]             state_q, state_d;
    logic [31:0]            prev_q, prev_d;
    logic [39:0]            unwrap_q, unwrap_d;
    logic [39:0]            sum_q, sum_d;
    logic [LOG2N-1:0]       cnt_q, cnt_d;
    logic [31:0]            freq_q, freq_d;
    logic                   ovld_q, ovld_d;

    logic                   accept;
    logic                   xfer;
    logic signed [32:0]     d_raw;
    logic signed [32:0]     d_wrap;
    logic signed [39:0]     d_ext;
    logic signed [39:0]     sum_nxt;
    logic signed [39:0]     avg;

    assign bus.in_ready   = ~ovld_q | bus.out_ready;
    assign bus.unwrap_out = unwrap_q;
    assign bus.freq_out   = freq_q;
    assign bus.out_valid  = ovld_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign xfer   = ovld_q & bus.out_ready;

    // Step folded into (-180, +180] deg so a jump across the +-180 seam reads as a short step.
    always_comb begin
        d_raw  = $signed({bus.phase_in[31], bus.phase_in}) - $signed({prev_q[31], prev_q});
        d_wrap = d_raw;
        if (d_raw > HALF_TURN)
            d_wrap = d_raw - FULL_TURN;
        else if (d_raw <= -HALF_TURN)
            d_wrap = d_raw + FULL_TURN;
        d_ext   = {{7{d_wrap[32]}}, d_wrap};
        sum_nxt = $signed(sum_q) + d_ext;
        avg     = sum_nxt >>> LOG2N;
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        unwrap_d = unwrap_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        freq_d   = freq_q;
        ovld_d   = ovld_q;

        if (clear) begin
            state_d = S_IDLE;
            sum_d   = '0;
            cnt_d   = '0;
            ovld_d  = 1'b0;
            freq_d  = '0;
        end else begin
            if (xfer)
                ovld_d = 1'b0;
            if (accept) begin
                prev_d = bus.phase_in;
                if (state_q == S_IDLE) begin
                    unwrap_d = {{8{bus.phase_in[31]}}, bus.phase_in};
                    state_d  = S_RUN;
                end else begin
                    unwrap_d = unwrap_q + d_ext;
                    // Count is all ones exactly when this diff closes the block.
                    if (&cnt_q) begin
                        freq_d = avg[31:0];
                        ovld_d = 1'b1;
                        sum_d  = '0;
                        cnt_d  = '0;
                    end else begin
                        sum_d = sum_nxt;
                        cnt_d = cnt_q + LOG2N'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prev_q   <= '0;
            unwrap_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            freq_q   <= '0;
            ovld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            unwrap_q <= unwrap_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            freq_q   <= freq_d;
            ovld_q   <= ovld_d;
        end
    end
endmodule

// File: tb/tb_cordic_phase_post.sv
// Bench for cordic_phase_post: vector table with a result scoreboard on an N=4 instance,
// hand sequences for backpressure and reset, and a long N=256 block on a second instance.
module tb_cordic_phase_post;
    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic clear_b;

    always #5 clk = ~clk;

    cordic_phase_post_if a_if ();
    cordic_phase_post_if b_if ();

    cordic_phase_post #(.LOG2N(2)) dut_a (.clk(clk), .rst(rst), .clear(clear),   .bus(a_if.slave));
    cordic_phase_post #(.LOG2N(8)) dut_b (.clk(clk), .rst(rst), .clear(clear_b), .bus(b_if.slave));

    typedef struct {
        bit     clr;
        bit     vld;
        bit     ordy;
        int     ph;
        bit     chku;
        longint expu;
        int     ov;     // expected out_valid after the edge, -1 = don't check
        bit     push;
        int     res;
    } vec_t;

    vec_t   tbl[$];
    int     exp_q[$];
    int     n_chk  = 0;
    int     n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic add(input bit clr, input bit vld, input int ph, input bit chku,
                       input longint expu, input int ov, input bit push, input int res);
        vec_t v;
        v.clr = clr; v.vld = vld; v.ordy = 1'b1; v.ph = ph; v.chku = chku;
        v.expu = expu; v.ov = ov; v.push = push; v.res = res;
        tbl.push_back(v);
    endtask

    // One clock on instance A; a transfer seen before the edge is scored against the queue.
    task automatic cyc(input bit clr, input bit vld, input bit ordy, input int ph);
        @(negedge clk);
        clear         = clr;
        a_if.in_valid = vld;
        a_if.phase_in = ph;
        a_if.out_ready = ordy;
        #1;
        if (a_if.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_result: got freq_out %0d expected no result", $signed(a_if.freq_out));
            end else begin
                chk("freq_out", longint'($signed(a_if.freq_out)), longint'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input int ph, input longint expu, input int ov);
        add(1'b0, 1'b1, ph, 1'b1, expu, ov, 1'b0, 0);
    endtask

    task automatic smp_res(input int ph, input longint expu, input int res);
        add(1'b0, 1'b1, ph, 1'b1, expu, 1, 1'b1, res);
    endtask

    task automatic clr_cyc(input longint expu);
        add(1'b1, 1'b1, 123, 1'b1, expu, 0, 1'b0, 0);
    endtask

    task automatic idle_cyc();
        add(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        longint p;

        rst = 1'b1; clear = 1'b0; clear_b = 1'b0;
        a_if.in_valid = 1'b0; a_if.phase_in = '0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.phase_in = '0; b_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  a_if.in_ready,  1);
        chk("rst_out_valid", a_if.out_valid, 0);
        chk("rst_unwrap",    longint'($signed(a_if.unwrap_out)), 0);
        chk("rst_freq",      longint'($signed(a_if.freq_out)),   0);

        // 10 deg steps
        smp(0, 0, 0);
        smp(655360, 655360, 0);
        smp(1310720, 1310720, 0);
        smp(1966080, 1966080, 0);
        smp_res(2621440, 2621440, 655360);
        idle_cyc();
        // clear discards the concurrent sample and keeps unwrap
        clr_cyc(2621440);
        smp(11141120, 11141120, 0);
        smp(-11141120, 12451840, 0);
        clr_cyc(12451840);
        smp(0, 0, 0);
        smp(-11796480, 11796480, 0);
        clr_cyc(11796480);
        smp(0, 0, 0);
        smp(11796480, 11796480, 0);
        // negative mean -5/4 floors to -2
        clr_cyc(11796480);
        smp(0, 0, 0);
        smp(-1, -1, 0);
        smp(-2, -2, 0);
        smp(-3, -3, 0);
        smp_res(-5, -5, -2);
        idle_cyc();
        // clear after two diffs restarts the block
        clr_cyc(-5);
        smp(0, 0, 0);
        smp(100, 100, 0);
        smp(200, 200, 0);
        clr_cyc(200);
        smp(1000, 1000, 0);
        smp(1100, 1100, 0);
        smp(1200, 1200, 0);
        smp(1300, 1300, 0);
        smp_res(1400, 1400, 100);
        idle_cyc();

        foreach (tbl[i]) begin
            if (tbl[i].push) exp_q.push_back(tbl[i].res);
            cyc(tbl[i].clr, tbl[i].vld, tbl[i].ordy, tbl[i].ph);
            if (tbl[i].chku) chk($sformatf("unwrap_v%0d", i), longint'($signed(a_if.unwrap_out)), tbl[i].expu);
            if (tbl[i].ov >= 0) chk($sformatf("out_valid_v%0d", i), longint'(a_if.out_valid), longint'(tbl[i].ov));
        end

        // Backpressure: result held, input stalled, prev preserved
        cyc(1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, k * 1000);
        exp_q.push_back(1000);
        cyc(1'b0, 1'b1, 1'b0, 4000);
        chk("bp_out_valid", a_if.out_valid, 1);
        chk("bp_in_ready",  a_if.in_ready,  0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 999999);
            chk("bp_hold_in_ready", a_if.in_ready,  0);
            chk("bp_hold_valid",    a_if.out_valid, 1);
            chk("bp_hold_freq",     longint'($signed(a_if.freq_out)),   1000);
            chk("bp_hold_unwrap",   longint'($signed(a_if.unwrap_out)), 4000);
        end
        cyc(1'b0, 1'b0, 1'b1, 0);
        chk("bp_release_in_ready",  a_if.in_ready,  1);
        chk("bp_release_out_valid", a_if.out_valid, 0);
        cyc(1'b0, 1'b1, 1'b1, 5000);
        chk("bp_prev_held_unwrap", longint'($signed(a_if.unwrap_out)), 5000);

        // Reset mid-block: partial sum dropped, next sample is an IDLE sample
        cyc(1'b0, 1'b1, 1'b1, 6000);
        @(negedge clk);
        rst = 1'b1;
        a_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_unwrap", longint'($signed(a_if.unwrap_out)), 0);
        chk("mid_rst_in_ready", a_if.in_ready, 1);
        cyc(1'b0, 1'b1, 1'b1, 7);
        chk("post_rst_idle_unwrap", longint'($signed(a_if.unwrap_out)), 7);
        for (int k = 1; k < 4; k++) cyc(1'b0, 1'b1, 1'b1, 7 + 10 * k);
        chk("post_rst_no_early", a_if.out_valid, 0);
        exp_q.push_back(10);
        cyc(1'b0, 1'b1, 1'b1, 47);
        chk("post_rst_result_valid", a_if.out_valid, 1);
        cyc(1'b0, 1'b0, 1'b1, 0);
        cyc(1'b0, 1'b0, 1'b1, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        // N = 256, steps of -179 deg with wrapped phase input
        p = 0;
        for (int k = 0; k < 257; k++) begin
            if (k > 0) begin
                p = p - 11730944;
                if (p < -11796480) p = p + 23592960;
            end
            @(negedge clk);
            b_if.in_valid = 1'b1;
            b_if.phase_in = 32'(p);
            @(posedge clk);
            #1;
            if (k == 255) chk("n256_no_early", b_if.out_valid, 0);
        end
        chk("n256_out_valid", b_if.out_valid, 1);
        chk("n256_freq",   longint'($signed(b_if.freq_out)),   -11730944);
        chk("n256_unwrap", longint'($signed(b_if.unwrap_out)), -64'sd3003121664);
        @(negedge clk);
        b_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("n256_transferred", b_if.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
